// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared types, constants and helpers for demux_router
package demux_pkg;

   // Widest drop counter supported; CNT_MAX is sliced down to the actual width.
   localparam int CNT_W_MAX = 32;
   localparam logic [CNT_W_MAX-1:0] CNT_MAX = '1;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry holding register with valid/ready on both sides
module demux_slot
   import demux_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);

   slot_state_t       state;
   logic [DATA_W-1:0] data_q;
   logic              wr;

   // A full slot still accepts when it drains in the same cycle.
   assign in_ready  = (state == SLOT_EMPTY) || out_ready;
   assign wr        = in_valid && in_ready;
   assign out_valid = (state == SLOT_FULL);
   assign out_data  = data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= SLOT_EMPTY;
         data_q <= '0;
      end else if (wr) begin
         state  <= SLOT_FULL;
         data_q <= in_data;
      end else if (out_ready && (state == SLOT_FULL)) begin
         state  <= SLOT_EMPTY;
      end
   end

endmodule

// File: rtl/demux_router.sv
// rtl/demux_router.sv - routes one valid/ready stream to NUM_OUT buffered outputs
module demux_router
   import demux_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int NUM_OUT = 4,
   parameter int SEL_W   = 2,
   parameter int CNT_W   = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_W-1:0]         in_data,
   input  logic [SEL_W-1:0]          in_sel,
   output logic [NUM_OUT-1:0]        out_valid,
   input  logic [NUM_OUT-1:0]        out_ready,
   output logic [NUM_OUT*DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]          drop_cnt,
   output logic                      err_sticky
);

   localparam int SEL_SPAN = 2 ** SEL_W;

   generate
      if (clog2(NUM_OUT) > SEL_W || CNT_W > CNT_W_MAX || NUM_OUT < 2) begin : g_bad_params
         $error("demux_router: illegal parameter combination");
      end
   endgenerate

   logic [NUM_OUT-1:0]  slot_ready;
   logic [NUM_OUT-1:0]  slot_wr;
   logic [SEL_SPAN-1:0] ready_span;
   logic                sel_ok;
   logic                drop;
   logic                cnt_sat;

   // Unused select codes read as ready so out-of-range beats are always consumed.
   always_comb begin
      ready_span                = '1;
      ready_span[NUM_OUT-1:0]   = slot_ready;
      sel_ok                    = (32'(in_sel) < NUM_OUT);
      in_ready                  = !rst && ready_span[in_sel];
      drop                      = in_valid && !rst && !sel_ok;
   end

   assign cnt_sat = (drop_cnt == CNT_MAX[CNT_W-1:0]);

   genvar k;
   generate
      for (k = 0; k < NUM_OUT; k++) begin : g_slot
         assign slot_wr[k] = in_valid && !rst && (in_sel == SEL_W'(k));

         demux_slot #(
            .DATA_W (DATA_W)
         ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (slot_wr[k]),
            .in_ready  (slot_ready[k]),
            .in_data   (in_data),
            .out_valid (out_valid[k]),
            .out_ready (out_ready[k]),
            .out_data  (out_data[k*DATA_W +: DATA_W])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt   <= '0;
         err_sticky <= 1'b0;
      end else if (drop) begin
         if (!cnt_sat) begin
            drop_cnt <= drop_cnt + 1'b1;
         end
         err_sticky <= 1'b1;
      end
   end

endmodule
